// File: rtl/mx_se.sv
// mx_se: two-input operand mux (register bank vs. sign-extended immediate)
// with a combinational result, a zero flag, and a one-cycle registered copy.
//
// Ports:
//   clk      - clock, registers update on rising edge
//   rst_n    - synchronous active-low reset (clears out_q / sel_q only)
//   in_RB    - register-bank operand, selected when S_MXSE = 0
//   in_SE    - sign-extended immediate operand, selected when S_MXSE = 1
//   S_MXSE   - source select
//   out      - combinational mux result (valid during reset)
//   out_zero - combinational flag, high when out is all zeros
//   out_q    - out registered, one-cycle latency
//   sel_q    - S_MXSE registered, aligned with out_q
module mx_se #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_RB,
    input  logic [WIDTH-1:0] in_SE,
    input  logic             S_MXSE,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q
);

    // Operand select; an unknown select is left unresolved so X propagates.
    assign out      = S_MXSE ? in_SE : in_RB;
    assign out_zero = (out == '0);

    // Registered copy of the mux result and its select; reset wins over capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= 1'b0;
        end else begin
            out_q <= out;
            sel_q <= S_MXSE;
        end
    end

endmodule

// File: tb/tb_mx_se.sv
// Testbench for mx_se: directed corner vectors plus a randomized sweep.
// Combinational outputs are checked directly against a reference mux;
// registered outputs go through an expectation queue drained by a monitor.
module tb_mx_se;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_RB;
    logic [WIDTH-1:0] in_SE;
    logic             S_MXSE;
    logic [WIDTH-1:0] out;
    logic             out_zero;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             sel;
    } exp_t;

    exp_t exp_q[$];
    bit   armed = 1'b0;

    mx_se #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_RB    (in_RB),
        .in_SE    (in_SE),
        .S_MXSE   (S_MXSE),
        .out      (out),
        .out_zero (out_zero),
        .out_q    (out_q),
        .sel_q    (sel_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference mux computed from the selection rule.
    function automatic logic [WIDTH-1:0] ref_mux(input logic [WIDTH-1:0] rb,
                                                 input logic [WIDTH-1:0] se,
                                                 input logic sel);
        if (sel) return se;
        return rb;
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Check combinational outputs against the reference after settling.
    task automatic chk_comb(input string name);
        logic [WIDTH-1:0] e;
        #1;
        e = ref_mux(in_RB, in_SE, S_MXSE);
        chk({name, "_out"}, out, e);
        chk({name, "_zero"}, WIDTH'(out_zero), WIDTH'(e == '0));
    endtask

    // Scoreboard producer: predict register contents from inputs at each edge.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) armed = 1'b1;
        if (armed) begin
            if (!rst_n) begin
                e.data = '0;
                e.sel  = 1'b0;
            end else begin
                e.data = ref_mux(in_RB, in_SE, S_MXSE);
                e.sel  = S_MXSE;
            end
            exp_q.push_back(e);
        end
    end

    // Scoreboard consumer: compare registered outputs just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_q", out_q, e.data);
            chk("sel_q", WIDTH'(sel_q), WIDTH'(e.sel));
        end
    end

    function automatic logic [WIDTH-1:0] rnd_operand();
        if ($urandom_range(7) == 0) return '0;
        return WIDTH'($urandom);
    endfunction

    initial begin
        rst_n  = 1'b0;
        in_RB  = 32'hFFFF0000;
        in_SE  = 32'h0000FFFF;
        S_MXSE = 1'b0;

        // Combinational path with no clock edge involved.
        #1;
        chk_comb("rb_sel");
        S_MXSE = 1'b1;
        chk_comb("se_sel");
        in_RB  = '0;
        in_SE  = 32'h12345678;
        S_MXSE = 1'b0;
        chk_comb("zero_rb");
        chk("zero_flag_hi", WIDTH'(out_zero), WIDTH'(1));
        S_MXSE = 1'b1;
        chk_comb("nonzero_se");
        chk("zero_flag_lo", WIDTH'(out_zero), WIDTH'(0));

        // Hold reset for two edges while out = 0000FFFF.
        in_RB  = 32'hFFFF0000;
        in_SE  = 32'h0000FFFF;
        S_MXSE = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("rst_out_hold", out, 32'h0000FFFF);
            chk("rst_out_q", out_q, '0);
            chk("rst_sel_q", WIDTH'(sel_q), WIDTH'(0));
        end

        // Release reset; select flips just after edge N.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        S_MXSE = 1'b0;
        #1;
        chk("edgeN_out_q", out_q, 32'h0000FFFF);
        chk("edgeN_sel_q", WIDTH'(sel_q), WIDTH'(1));
        @(posedge clk);
        #2;
        chk("edgeN1_out_q", out_q, 32'hFFFF0000);
        chk("edgeN1_sel_q", WIDTH'(sel_q), WIDTH'(0));

        // Mid-operation reset assertion leaves the mux path alone.
        @(negedge clk);
        S_MXSE = 1'b1;
        rst_n  = 1'b0;
        chk_comb("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Random sweep with occasional reset pulses.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            in_RB  = rnd_operand();
            in_SE  = rnd_operand();
            S_MXSE = 1'($urandom_range(1));
            rst_n  = ($urandom_range(49) != 0);
            chk_comb("rand");
        end

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected at most 1", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mx_se.md
MX_SE -- requirements
Module: mx_se

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits for in_RB, in_SE, out and out_q.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled only on rising clk.
REQ-004 in_RB  input  WIDTH  register-bank operand (select 0 source).
REQ-005 in_SE  input  WIDTH  sign-extended immediate operand (select 1 source).
REQ-006 S_MXSE  input  1  source select: 0 = in_RB, 1 = in_SE.
REQ-007 out  output  WIDTH  combinational mux result.
REQ-008 out_q  output  WIDTH  registered copy of out, one-cycle latency.
REQ-009 out_zero  output  1  combinational flag, high when out == 0.
REQ-010 sel_q  output  1  registered copy of S_MXSE, aligned with out_q.

Function
REQ-011 out SHALL equal in_RB when S_MXSE = 0 and in_SE when S_MXSE = 1, bit-exact, no sign or zero manipulation.
REQ-012 out SHALL be purely combinational: it settles within the same delta/time step as any input change, with no clock edge required.
REQ-013 out and out_zero SHALL be independent of clk and rst_n, so out is valid during reset.
REQ-014 S_MXSE = X/Z SHALL not be resolved by the block; simulation propagates X on out, and out is not constrained in that case.
REQ-015 out_zero SHALL be 1 exactly when all WIDTH bits of out are 0, else 0.
REQ-016 On each rising clk with rst_n = 1, out_q SHALL load the current out value and sel_q SHALL load S_MXSE.
REQ-017 out_q and sel_q SHALL hold their values between rising clk edges regardless of input changes.
REQ-018 Inputs changing in the same cycle as the edge SHALL be captured per their value at the edge (standard setup semantics); no glitch filtering.
REQ-019 The block SHALL contain no other state, handshake, or state machine.

Reset
REQ-020 A rising clk with rst_n = 0 SHALL set out_q to all zeros and sel_q to 0; reset has priority over data capture.
REQ-021 Deasserting rst_n SHALL resume normal capture on the first rising clk where rst_n = 1.
REQ-022 Asserting rst_n mid-operation SHALL only clear the registered outputs at the next rising clk, with no effect on out or out_zero.
REQ-023 Before the first reset edge, out_q and sel_q SHALL be unknown; the bench does not check them until then.

Verification
REQ-024 in_RB = 32'hFFFF0000, in_SE = 32'h0000FFFF, S_MXSE = 0, wait 1 time unit with no clock -> out = 32'hFFFF0000, out_zero = 0.
REQ-025 Same data, S_MXSE = 1, wait 1 time unit -> out = 32'h0000FFFF, out_zero = 0.
REQ-026 in_RB = 0, in_SE = 32'h12345678, S_MXSE = 0 -> out = 0, out_zero = 1; toggle S_MXSE = 1 -> out = 32'h12345678, out_zero = 0.
REQ-027 rst_n = 0 for 2 clocks while out = 32'h0000FFFF -> out_q = 0 and sel_q = 0, and out stays 32'h0000FFFF throughout.
REQ-028 rst_n = 1, S_MXSE = 1 at edge N, and S_MXSE = 0 just after edge N -> out_q = 32'h0000FFFF and sel_q = 1 after edge N, then out_q = 32'hFFFF0000 and sel_q = 0 after edge N+1.
REQ-029 Random sweep of 1000 vectors -> out matches the reference mux on every vector, and out_q equals the previous cycle's out on every cycle after reset.
